// File: rtl/dmem_ctl_pkg.sv
// Shared definitions for the M-stage data-memory controller: byte-lane
// encodings (bit 3 = byte 0, big-endian) and the one-hot FSM state.
package dmem_ctl_pkg;

  localparam logic [3:0] BE_B0 = 4'b1000;
  localparam logic [3:0] BE_B1 = 4'b0100;
  localparam logic [3:0] BE_B2 = 4'b0010;
  localparam logic [3:0] BE_B3 = 4'b0001;
  localparam logic [3:0] BE_H0 = 4'b1100;
  localparam logic [3:0] BE_H1 = 4'b0011;
  localparam logic [3:0] BE_W  = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_REQ  = 3'b010,
    ST_DONE = 3'b100
  } dm_state_t;

endpackage

// File: rtl/dload_align.sv
// Load-data lane select and sign/zero extension, driven by the captured
// byte enables of the access.
module dload_align
  import dmem_ctl_pkg::*;
(
  input  logic [3:0]  byen,
  input  logic        sgn,
  input  logic [31:0] rdata,
  output logic [31:0] ldata
);

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic s);
    logic signed [7:0]  bs;
    logic signed [31:0] bx;
    bs = b;
    bx = bs;
    return s ? bx : {24'd0, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic s);
    logic signed [15:0] hs;
    logic signed [31:0] hx;
    hs = h;
    hx = hs;
    return s ? hx : {16'd0, h};
  endfunction

  always_comb begin
    ldata = rdata;
    case (byen)
      BE_B0:   ldata = ext8(rdata[31:24], sgn);
      BE_B1:   ldata = ext8(rdata[23:16], sgn);
      BE_B2:   ldata = ext8(rdata[15:8], sgn);
      BE_B3:   ldata = ext8(rdata[7:0], sgn);
      BE_H0:   ldata = ext16(rdata[31:16], sgn);
      BE_H1:   ldata = ext16(rdata[15:0], sgn);
      BE_W:    ldata = rdata;
      default: ldata = rdata;
    endcase
  end

endmodule

// File: rtl/dmem_ctl.sv
// M-stage data-memory controller: captures the E-stage access, runs one
// request/acknowledge per load or store, stalls until ACK, registers load data.
module dmem_ctl
  import dmem_ctl_pkg::*;
(
  input  logic        SYSCLK,
  input  logic        RESET_D2_R_N,
  input  logic        CLMI_RHOLD,
  input  logic [31:0] DADDR_E,
  input  logic [3:0]  DBYEN_E,
  input  logic        DWORD_E,
  input  logic        DADALERR_E,
  input  logic        DREAD_E,
  input  logic        DWRITE_E,
  input  logic        DSIGNED_E,
  input  logic [31:0] ADATAREG_M_R,
  output logic        DM_REQ,
  output logic        DM_WR,
  output logic [31:0] DM_ADDR,
  output logic [3:0]  DM_BE,
  output logic [31:0] DM_WDATA,
  input  logic        DM_ACK,
  input  logic [31:0] DM_RDATA,
  output logic        DM_HOLD,
  output logic [31:0] LDATA_W_R,
  output logic        LDVALID_W_R,
  output logic        DADALERR_M_R
);

  logic [31:0] addr_p1;
  logic [3:0]  byen_p1;
  logic        sgn_p1;
  logic        rd_p1;
  logic        wr_p1;
  logic        alerr_p1;
  logic        vld_p1;

  dm_state_t   state;
  dm_state_t   state_nxt;
  logic        req_act;
  logic        ack_ev;
  logic [31:0] ldata_al;

  // Word access and low address bits are implied by the byte enables.
  logic        unused_bits;
  assign unused_bits = ^{addr_p1[1:0], DWORD_E};

  // ---- E -> M capture ----
  always_ff @(posedge SYSCLK or negedge RESET_D2_R_N) begin
    if (!RESET_D2_R_N) begin
      addr_p1  <= '0;
      byen_p1  <= '0;
      sgn_p1   <= 1'b0;
      rd_p1    <= 1'b0;
      wr_p1    <= 1'b0;
      alerr_p1 <= 1'b0;
    end else if (!CLMI_RHOLD) begin
      addr_p1  <= DADDR_E;
      byen_p1  <= DBYEN_E;
      sgn_p1   <= DSIGNED_E;
      rd_p1    <= DREAD_E;
      wr_p1    <= DWRITE_E;
      alerr_p1 <= DADALERR_E;
    end
  end

  assign vld_p1       = (rd_p1 | wr_p1) & ~alerr_p1;
  assign DADALERR_M_R = alerr_p1 & (rd_p1 | wr_p1);

  // ---- M-stage request FSM ----
  always_ff @(posedge SYSCLK or negedge RESET_D2_R_N) begin
    if (!RESET_D2_R_N) state <= ST_IDLE;
    else               state <= state_nxt;
  end

  // A fresh capture in IDLE requests in the same cycle, so IDLE+valid acts as REQ.
  always_comb begin
    state_nxt = state;
    req_act   = 1'b0;
    case (state)
      ST_IDLE, ST_REQ: begin
        if (state == ST_REQ || vld_p1) begin
          req_act = 1'b1;
          if (!DM_ACK)         state_nxt = ST_REQ;
          else if (CLMI_RHOLD) state_nxt = ST_DONE;
          else                 state_nxt = ST_IDLE;
        end
      end
      ST_DONE: begin
        if (!CLMI_RHOLD) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign ack_ev   = req_act & DM_ACK;
  assign DM_REQ   = req_act;
  assign DM_WR    = req_act & wr_p1;
  assign DM_ADDR  = req_act ? {addr_p1[31:2], 2'b00} : 32'd0;
  assign DM_BE    = req_act ? byen_p1 : 4'd0;
  assign DM_WDATA = req_act ? ADATAREG_M_R : 32'd0;
  assign DM_HOLD  = req_act & ~DM_ACK;

  dload_align u_align (
    .byen  (byen_p1),
    .sgn   (sgn_p1),
    .rdata (DM_RDATA),
    .ldata (ldata_al)
  );

  // ---- M -> W load result ----
  always_ff @(posedge SYSCLK or negedge RESET_D2_R_N) begin
    if (!RESET_D2_R_N) begin
      LDATA_W_R   <= '0;
      LDVALID_W_R <= 1'b0;
    end else if (ack_ev) begin
      if (rd_p1 && !wr_p1) begin
        LDATA_W_R   <= ldata_al;
        LDVALID_W_R <= 1'b1;
      end else begin
        LDVALID_W_R <= 1'b0;
      end
    end else if (!CLMI_RHOLD) begin
      LDVALID_W_R <= 1'b0;
    end
  end

endmodule
